// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------------+
// | cpu_pkg : shared fetch types, decoded-instruction layout and opcodes      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    ST_OP   = 2'd0,
    ST_REG  = 2'd1,
    ST_IMM1 = 2'd2,
    ST_IMM2 = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [2:0]  dst;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic        hasimm1;
    logic        hasimm2;
    logic [7:0]  imm1;
    logic [7:0]  imm2;
    logic [15:0] pc;
    logic [15:0] next_pc;
  } instr_t;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_HLT = 5'b11111;

  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// +--------------------------------------------------------------------------+
// | instr_fifo : DEPTH-entry queue of decoded instructions, flushable         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  instr_t        i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output instr_t        o_head,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   c_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   c_DEPTH = CW'(DEPTH);

  instr_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == c_LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && (r_count != c_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is a pure register read, so valid/fields never see rom_data or ready.
  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// +--------------------------------------------------------------------------+
// | instr_fetch : byte-serial fetch FSM assembling 2..4 byte instructions     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [4:0]  instr_opcode,
  output logic [2:0]  instr_dst,
  output logic [2:0]  instr_src1,
  output logic [2:0]  instr_src2,
  output logic        instr_hasimm1,
  output logic        instr_hasimm2,
  output logic [7:0]  instr_imm1,
  output logic [7:0]  instr_imm2,
  output logic [15:0] instr_pc,
  output logic [15:0] instr_next_pc,
  output logic        halted
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [15:0]   r_pc;
  logic [15:0]   w_pc_nxt;
  instr_t        r_cur;
  instr_t        w_cur_nxt;
  instr_t        w_head;
  logic          r_halted;
  logic          w_consume;
  logic          w_push;
  logic          w_pop;
  logic          w_space;
  logic          w_valid;
  logic [CW-1:0] w_count;

  assign w_space = (w_count < c_DEPTH);
  assign w_pop   = w_valid & instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_state <= ST_OP;
    else if (redirect_valid) r_state <= ST_OP;
    else                     r_state <= w_state_nxt;
  end

  // w_cur_nxt is the instruction as it will look after this byte; on the
  // final byte it is pushed directly, so completion costs no extra cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_consume   = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      ST_OP: begin
        if (w_space && !r_halted) begin
          w_consume         = 1'b1;
          w_cur_nxt         = '0;
          w_cur_nxt.opcode  = rom_data[4:0];
          w_cur_nxt.dst     = rom_data[7:5];
          w_cur_nxt.pc      = r_pc;
          w_state_nxt       = ST_REG;
        end
      end
      ST_REG: begin
        w_consume         = 1'b1;
        w_cur_nxt.hasimm1 = rom_data[7];
        w_cur_nxt.hasimm2 = rom_data[6];
        w_cur_nxt.src1    = rom_data[5:3];
        w_cur_nxt.src2    = rom_data[2:0];
        if (rom_data[7])      w_state_nxt = ST_IMM1;
        else if (rom_data[6]) w_state_nxt = ST_IMM2;
        else begin
          w_push      = 1'b1;
          w_state_nxt = ST_OP;
        end
      end
      ST_IMM1: begin
        w_consume      = 1'b1;
        w_cur_nxt.imm1 = rom_data;
        if (r_cur.hasimm2) w_state_nxt = ST_IMM2;
        else begin
          w_push      = 1'b1;
          w_state_nxt = ST_OP;
        end
      end
      ST_IMM2: begin
        w_consume      = 1'b1;
        w_cur_nxt.imm2 = rom_data;
        w_push         = 1'b1;
        w_state_nxt    = ST_OP;
      end
      default: w_state_nxt = ST_OP;
    endcase
    if (w_consume) w_cur_nxt.next_pc = pc_inc(r_pc);
    w_pc_nxt = w_consume ? pc_inc(r_pc) : r_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_cur    <= '0;
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_pc     <= redirect_pc;
      r_cur    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_cur <= w_cur_nxt;
      if (w_push && (w_cur_nxt.opcode == OP_HLT)) r_halted <= 1'b1;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_cur_nxt),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_valid     (w_valid),
    .o_count     (w_count)
  );

  assign rom_addr      = r_pc;
  assign halted        = r_halted;
  assign instr_valid   = w_valid;
  assign instr_opcode  = w_head.opcode;
  assign instr_dst     = w_head.dst;
  assign instr_src1    = w_head.src1;
  assign instr_src2    = w_head.src2;
  assign instr_hasimm1 = w_head.hasimm1;
  assign instr_hasimm2 = w_head.hasimm2;
  assign instr_imm1    = w_head.imm1;
  assign instr_imm2    = w_head.imm2;
  assign instr_pc      = w_head.pc;
  assign instr_next_pc = w_head.next_pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// +--------------------------------------------------------------------------+
// | tb_instr_fetch : directed bench with instruction-stream reference model   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [15:0] rom_addr, rom_addr2;
  logic [7:0]  rom_data, rom_data2;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid, instr_ready, valid2, ready2;
  logic [4:0]  instr_opcode, op2;
  logic [2:0]  instr_dst, instr_src1, instr_src2, dst2, src1_2, src2_2;
  logic        instr_hasimm1, instr_hasimm2, h1_2, h2_2;
  logic [7:0]  instr_imm1, instr_imm2, imm1_2, imm2_2;
  logic [15:0] instr_pc, instr_next_pc, pc2, npc2;
  logic        halted, halted2;

  logic [7:0]  rom [0:65535];
  int          n_chk = 0;
  int          n_fail = 0;

  logic        chk_en = 1'b0;
  logic        m_done = 1'b0;
  logic        prev_redir = 1'b0;
  logic [15:0] m_pc = 16'h0;

  assign rom_data  = rom[rom_addr];
  assign rom_data2 = rom[rom_addr2];

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(16'h0000), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_dst(instr_dst),
    .instr_src1(instr_src1), .instr_src2(instr_src2),
    .instr_hasimm1(instr_hasimm1), .instr_hasimm2(instr_hasimm2),
    .instr_imm1(instr_imm1), .instr_imm2(instr_imm2),
    .instr_pc(instr_pc), .instr_next_pc(instr_next_pc), .halted(halted)
  );

  instr_fetch #(.RESET_PC(16'hFFFF), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .instr_valid(valid2), .instr_ready(ready2),
    .instr_opcode(op2), .instr_dst(dst2),
    .instr_src1(src1_2), .instr_src2(src2_2),
    .instr_hasimm1(h1_2), .instr_hasimm2(h2_2),
    .instr_imm1(imm1_2), .instr_imm2(imm2_2),
    .instr_pc(pc2), .instr_next_pc(npc2), .halted(halted2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference decode straight from the ROM image: instruction length follows
  // the immediate flags in the second byte; absent immediates read as zero.
  function automatic logic [63:0] model_head(input logic [15:0] pc, output logic [15:0] nxt);
    logic [7:0]  b0, b1, i1, i2;
    logic [15:0] a;
    b0 = rom[pc];
    a  = pc + 16'd1;
    b1 = rom[a];
    a  = pc + 16'd2;
    i1 = 8'h00;
    i2 = 8'h00;
    if (b1[7]) begin i1 = rom[a]; a = a + 16'd1; end
    if (b1[6]) begin i2 = rom[a]; a = a + 16'd1; end
    nxt = a;
    return {b0[4:0], b0[7:5], b1[5:3], b1[2:0], b1[7], b1[6], i1, i2, pc, a};
  endfunction

  always @(negedge clk) begin
    logic [63:0] exp_h;
    logic [15:0] nxt;
    if (chk_en && rst_n) begin
      if (prev_redir) chk("valid_after_redirect", 64'(instr_valid), 64'd0);
      if (m_done)     chk("no_issue_after_halt", 64'(instr_valid), 64'd0);
      if (instr_valid && instr_ready && !redirect_valid) begin
        exp_h = model_head(m_pc, nxt);
        chk("head_stream", {instr_opcode, instr_dst, instr_src1, instr_src2,
                            instr_hasimm1, instr_hasimm2, instr_imm1, instr_imm2,
                            instr_pc, instr_next_pc}, exp_h);
        m_pc = nxt;
        if (exp_h[63:59] == 5'h1F) m_done = 1'b1;
      end
      prev_redir = redirect_valid;
    end else begin
      prev_redir = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
  endtask

  task automatic hold_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic release_reset();
    rst_n  = 1'b1;
    m_pc   = 16'h0000;
    m_done = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0;
    instr_ready = 1'b0; ready2 = 1'b0;
    clear_rom();
    tick();
    tick();
    chk("reset_addr", 64'(rom_addr), 64'd0);
    chk("reset_valid", 64'(instr_valid), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    chk("reset_fields", {instr_opcode, instr_pc, instr_next_pc}, 64'd0);

    // 2-byte instruction
    rom[0] = 8'h21; rom[1] = 8'h0A;
    instr_ready = 1'b1;
    release_reset();
    chk("t1_addr_c0", 64'(rom_addr), 64'd0);
    chk("t1_valid_c0", 64'(instr_valid), 64'd0);
    tick();
    chk("t1_addr_c1", 64'(rom_addr), 64'd1);
    chk("t1_valid_c1", 64'(instr_valid), 64'd0);
    tick();
    chk("t1_valid_c2", 64'(instr_valid), 64'd1);
    chk("t1_regs", 64'({instr_opcode, instr_dst, instr_src1, instr_src2}),
        64'({5'd1, 3'd1, 3'd1, 3'd2}));
    chk("t1_pcs", 64'({instr_pc, instr_next_pc}), 64'({16'h0000, 16'h0002}));
    chk("t1_imms", 64'({instr_hasimm1, instr_hasimm2, instr_imm1, instr_imm2}), 64'd0);
    repeat (4) tick();

    // 4-byte instruction
    hold_reset();
    clear_rom();
    rom[0] = 8'h41; rom[1] = 8'hC0; rom[2] = 8'h05; rom[3] = 8'h07;
    release_reset();
    for (int c = 0; c < 4; c++) begin
      chk("t2_addr", 64'(rom_addr), 64'(c));
      chk("t2_valid_early", 64'(instr_valid), 64'd0);
      tick();
    end
    chk("t2_valid_c4", 64'(instr_valid), 64'd1);
    chk("t2_fields", 64'({instr_opcode, instr_dst, instr_hasimm1, instr_hasimm2,
                          instr_imm1, instr_imm2, instr_next_pc}),
        64'({5'd1, 3'd2, 1'b1, 1'b1, 8'h05, 8'h07, 16'h0004}));
    repeat (4) tick();

    // back-pressure: queue fills, fetch freezes, resume in order
    hold_reset();
    clear_rom();
    for (int i = 0; i < 16; i++) begin
      rom[2*i]   = 8'(i + 1);
      rom[2*i+1] = 8'(i & 7);
    end
    instr_ready = 1'b0;
    release_reset();
    repeat (10) tick();
    chk("t3_addr_frozen", 64'(rom_addr), 64'd4);
    chk("t3_valid", 64'(instr_valid), 64'd1);
    chk("t3_head_pc", 64'(instr_pc), 64'd0);
    repeat (3) tick();
    chk("t3_addr_still", 64'(rom_addr), 64'd4);
    instr_ready = 1'b1;
    tick();
    chk("t3_second_pc", 64'(instr_pc), 64'd2);
    repeat (14) tick();
    chk("t3_model_progress", 64'(m_pc > 16'd10), 64'd1);

    // redirect during IMM1 with one queued entry
    hold_reset();
    clear_rom();
    rom[0] = 8'h01; rom[1] = 8'h00; rom[2] = 8'h02; rom[3] = 8'h80;
    rom[4] = 8'h33; rom[16'h100] = 8'h05; rom[16'h101] = 8'h09;
    instr_ready = 1'b0;
    release_reset();
    repeat (4) tick();
    chk("t4_addr_imm1", 64'(rom_addr), 64'd4);
    chk("t4_one_queued", 64'(instr_valid), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 16'h0100; m_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    chk("t4_flushed", 64'(instr_valid), 64'd0);
    chk("t4_addr_redir", 64'(rom_addr), 64'h100);
    tick();
    chk("t4_addr_next", 64'(rom_addr), 64'h101);
    tick();
    chk("t4_first_after", 64'({instr_valid, instr_opcode, instr_pc}),
        64'({1'b1, 5'd5, 16'h0100}));
    repeat (3) tick();

    // halt then redirect
    hold_reset();
    clear_rom();
    rom[16'h10] = 8'h1F; rom[16'h12] = 8'h03;
    instr_ready = 1'b1;
    release_reset();
    tick();
    chk("t5_not_halted", 64'(halted), 64'd0);
    repeat (30) tick();
    chk("t5_halted", 64'(halted), 64'd1);
    chk("t5_addr_held", 64'(rom_addr), 64'h12);
    tick();
    chk("t5_addr_held2", 64'(rom_addr), 64'h12);
    chk("t5_model_saw_halt", 64'(m_done), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 16'h0012; m_pc = 16'h0012; m_done = 1'b0;
    tick();
    redirect_valid = 1'b0;
    chk("t5_halt_cleared", 64'(halted), 64'd0);
    chk("t5_addr_redir", 64'(rom_addr), 64'h12);
    tick();
    chk("t5_fetching", 64'(rom_addr), 64'h13);
    repeat (4) tick();
    hold_reset();

    // RESET_PC=FFFF instance: wrap and mid-instruction reset
    clear_rom();
    rom[16'hFFFF] = 8'h23; rom[0] = 8'h1B;
    rst2_n = 1'b1;
    chk("t6_addr_c0", 64'(rom_addr2), 64'hFFFF);
    tick();
    chk("t6_addr_wrap", 64'(rom_addr2), 64'h0000);
    tick();
    chk("t6_instr", 64'({valid2, op2, dst2, src1_2, src2_2, pc2, npc2}),
        64'({1'b1, 5'd3, 3'd1, 3'd3, 3'd3, 16'hFFFF, 16'h0001}));
    tick();
    chk("t6_in_reg", 64'(rom_addr2), 64'd2);
    rst2_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(valid2), 64'd0);
    chk("t6_async_fields", 64'({op2, pc2, npc2}), 64'd0);
    chk("t6_async_addr", 64'({halted2, rom_addr2}), 64'hFFFF);
    tick();
    rst2_n = 1'b1;
    chk("t6_restart", 64'(rom_addr2), 64'hFFFF);
    tick();
    chk("t6_restart_wrap", 64'(rom_addr2), 64'h0000);
    tick();
    chk("t6_restart_instr", 64'({valid2, pc2}), 64'({1'b1, 16'hFFFF}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
